set_bit_serializer: RTL and testbench
=====================================

// Module: set_bit_serializer
// PURPOSE
//   Accepts a WIDTH-bit request vector over a valid/ready handshake. Emits one beat per set bit, scanning from the LSB upward.
//   Each beat carries the bit position as one-hot and binary, the beat's ordinal within the vector, and a last flag.
//   Sits upstream of the set-bit selection logic. The beat with seq==1 is the second set bit from the LSB.
//   Converts a parallel request word into a sequential, back-pressurable stream.
// PARAMETERS
//   WIDTH  12                 request vector width; must be >= 2
//   IDXW   $clog2(WIDTH)      width of index/sequence fields (derived, not overridable)
// PORTS
//   clk            in   1      clock; all state updates on rising edge
//   resetn         in   1      synchronous reset, active low
//   in_valid_i     in   1      vec_i valid
//   in_ready_o     out  1      block can accept vec_i this cycle
//   vec_i          in   WIDTH  request vector
//   out_valid_o    out  1      beat valid
//   out_ready_i    in   1      consumer accepts beat
//   out_onehot_o   out  WIDTH  one-hot position of current set bit
//   out_idx_o      out  IDXW   binary position of current set bit
//   out_seq_o      out  IDXW   ordinal of this beat within the vector (0 = first set bit)
//   out_last_o     out  1      no further set bits remain after this beat
// BEHAVIOUR
//   Reset (resetn==0 at clk edge)
//     - state=IDLE, pending=0; out_valid_o=0; out_onehot_o/out_idx_o/out_seq_o/out_last_o=0.
//     - in_ready_o=1 from the first cycle after reset.
//     - Reset mid-scan discards all remaining bits; no further beats from that vector.
//   States
//     - IDLE: in_ready_o=1, out_valid_o=0.
//     - EMIT: out_valid_o=1.
//   Accept (in_valid_i && in_ready_o)
//     - pending<=vec_i, seq<=0.
//     - vec_i!=0 -> EMIT. The first beat is valid the next cycle (1-cycle latency).
//     - vec_i==0 -> stay IDLE. The vector is consumed silently: no beat, in_ready_o stays 1.
//   Beat contents (EMIT)
//     - out_onehot_o = lowest set bit of pending; out_idx_o = its binary index; out_seq_o = seq.
//     - out_last_o = ((pending & ~out_onehot_o) == 0).
//   Beat handshake (out_valid_o && out_ready_i)
//     - pending<=pending & ~out_onehot_o; seq<=seq+1.
//     - If out_last_o: -> IDLE, unless a new vector is accepted the same cycle (see below).
//   Backpressure
//     - While out_valid_o && !out_ready_i, all out_* signals hold stable and pending is unchanged.
//   Overlap
//     - in_ready_o = IDLE || (out_valid_o && out_ready_i && out_last_o). This is a combinational path from out_ready_i.
//     - A vector accepted on the last-beat handshake loads pending directly. Its first beat follows the next cycle with no bubble.
//     - If that vector is 0: -> IDLE.
//   Width rules
//     - seq never exceeds WIDTH-1, so IDXW bits suffice; no wrap.
//     - Beats per vector = popcount(vec_i), in range 0..WIDTH.
//   in_valid_i while in_ready_o==0: ignored; upstream must hold vec_i stable until accepted.
// STRUCTURE
//   Package set_bit_pkg
//     - state_e enum {IDLE, EMIT}.
//     - function idx_w(width) returning $clog2(width).
//   Sub-module lsb_onehot #(WIDTH)
//     - Combinational; inputs vec; outputs onehot, idx, any.
//     - One instance on pending.
//   Top-level registers: state, pending, seq. Out fields derive from pending through lsb_onehot.
// TESTING
//   1. vec_i=12'h0A4, out_ready_i=1 -> beats idx 2,5,7; seq 0,1,2; out_last_o=1 only on idx 7; onehot 004,020,080.
//   2. vec_i=12'h000 -> accepted in 1 cycle; out_valid_o never asserts; in_ready_o stays 1.
//   3. vec_i=12'h801, out_ready_i low 3 cycles -> idx 0 beat held stable 3 cycles; then idx 0, idx 11 (last).
//   4. A=12'h003 then B=12'h010 with in_valid_i held -> B accepted on A's idx 1 last handshake; B's idx 4 beat the next cycle, no bubble.
//   5. vec_i=12'hFFF -> 12 consecutive beats idx 0..11; seq 0..11; last on idx 11; in_ready_o=0 until that handshake.
//   6. vec_i=12'h0F0, resetn=0 after the first beat -> next cycle out_valid_o=0, in_ready_o=1; no idx 5..7 beats appear.

Source files
------------

// File: rtl/set_bit_pkg.sv
// Shared types and helpers for the set-bit serializer.
package set_bit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic int idx_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/set_bit_serializer_lsb_onehot.sv
// Lowest-set-bit finder: one-hot mask, binary index and a non-zero flag.
module lsb_onehot
  import set_bit_pkg::*;
#(
  parameter int WIDTH = 12,
  localparam int IDXW = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] onehot,
  output logic [IDXW-1:0]  idx,
  output logic             any
);

  // Two's-complement trick isolates the lowest set bit.
  always_comb begin
    onehot = vec & (~vec + WIDTH'(1));
    any    = |vec;
  end

  // Scan from the top down so the lowest set bit writes last and wins.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDXW'(i);
    end
  end

endmodule

// File: rtl/set_bit_serializer.sv
// Serializes a request vector into one back-pressurable beat per set bit,
// scanning from the LSB upward.
//
//   state | meaning
//   IDLE  | waiting for a vector; in_ready_o=1, no beat presented
//   EMIT  | presenting the lowest remaining set bit of pending as a beat
module set_bit_serializer
  import set_bit_pkg::*;
#(
  parameter int WIDTH = 12,
  localparam int IDXW = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] vec_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_onehot_o,
  output logic [IDXW-1:0]  out_idx_o,
  output logic [IDXW-1:0]  out_seq_o,
  output logic             out_last_o
);

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] pending;
  logic [IDXW-1:0]  seq;

  logic [WIDTH-1:0] low_onehot;
  logic [IDXW-1:0]  low_idx;
  logic             low_any;
  logic             low_last;
  logic             beat_fire;
  logic             accept;

  lsb_onehot #(.WIDTH(WIDTH)) u_lsb (
    .vec    (pending),
    .onehot (low_onehot),
    .idx    (low_idx),
    .any    (low_any)
  );

  // Handshake qualifiers shared by the FSM and the datapath.
  always_comb begin
    low_last  = ((pending & ~low_onehot) == '0);
    beat_fire = (state == EMIT) && out_ready_i;
    accept    = in_valid_i && in_ready_o;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; a vector accepted on the last beat chains straight into EMIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && (vec_i != '0)) state_next = EMIT;
      end
      EMIT: begin
        if (beat_fire && low_last) begin
          if (accept && (vec_i != '0)) state_next = EMIT;
          else                         state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic; beat fields are forced to zero outside EMIT.
  always_comb begin
    out_valid_o  = 1'b0;
    out_onehot_o = '0;
    out_idx_o    = '0;
    out_seq_o    = '0;
    out_last_o   = 1'b0;
    in_ready_o   = 1'b0;
    case (state)
      IDLE: in_ready_o = 1'b1;
      EMIT: begin
        out_valid_o  = low_any;
        out_onehot_o = low_onehot;
        out_idx_o    = low_idx;
        out_seq_o    = seq;
        out_last_o   = low_last;
        in_ready_o   = out_ready_i && low_last;
      end
      default: in_ready_o = 1'b0;
    endcase
  end

  // Pending bits and beat ordinal; a new vector takes priority over clearing the old bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending <= '0;
      seq     <= '0;
    end else if (accept) begin
      pending <= vec_i;
      seq     <= '0;
    end else if (beat_fire) begin
      pending <= pending & ~low_onehot;
      seq     <= seq + IDXW'(1);
    end
  end

endmodule

// File: tb/tb_set_bit_serializer.sv
// Directed bench for set_bit_serializer: inputs driven and outputs sampled on
// the falling edge, state advances on the rising edge.
module tb_set_bit_serializer;

  localparam int WIDTH = 12;
  localparam int IDXW  = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] vec_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_onehot_o;
  logic [IDXW-1:0]  out_idx_o;
  logic [IDXW-1:0]  out_seq_o;
  logic             out_last_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  set_bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .vec_i        (vec_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_onehot_o (out_onehot_o),
    .out_idx_o    (out_idx_o),
    .out_seq_o    (out_seq_o),
    .out_last_o   (out_last_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_beat(input string tag, input int idx, input int onehot,
                            input int seq, input bit last, input bit rdy);
    check({tag, ".valid"},  32'(out_valid_o),  32'd1);
    check({tag, ".idx"},    32'(out_idx_o),    32'(idx));
    check({tag, ".onehot"}, 32'(out_onehot_o), 32'(onehot));
    check({tag, ".seq"},    32'(out_seq_o),    32'(seq));
    check({tag, ".last"},   32'(out_last_o),   32'(last));
    check({tag, ".ready"},  32'(in_ready_o),   32'(rdy));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"},  32'(out_valid_o),  32'd0);
    check({tag, ".ready"},  32'(in_ready_o),   32'd1);
    check({tag, ".onehot"}, 32'(out_onehot_o), 32'd0);
    check({tag, ".idx"},    32'(out_idx_o),    32'd0);
    check({tag, ".seq"},    32'(out_seq_o),    32'd0);
    check({tag, ".last"},   32'(out_last_o),   32'd0);
  endtask

  initial begin
    resetn      = 1'b0;
    in_valid_i  = 1'b0;
    vec_i       = '0;
    out_ready_i = 1'b1;
    step();
    step();
    check_idle("reset");
    resetn = 1'b1;
    step();
    check_idle("post_reset");

    // 1: 0x0A4 -> idx 2,5,7
    in_valid_i = 1'b1; vec_i = 12'h0A4;
    check("t1.accept_ready", 32'(in_ready_o), 32'd1);
    step();
    in_valid_i = 1'b0;
    check_beat("t1.b0", 2, 12'h004, 0, 1'b0, 1'b0);
    step();
    check_beat("t1.b1", 5, 12'h020, 1, 1'b0, 1'b0);
    step();
    check_beat("t1.b2", 7, 12'h080, 2, 1'b1, 1'b1);
    step();
    check_idle("t1.done");

    // 2: zero vector consumed silently
    in_valid_i = 1'b1; vec_i = 12'h000;
    check("t2.accept_ready", 32'(in_ready_o), 32'd1);
    step();
    in_valid_i = 1'b0;
    check_idle("t2.after");
    step();
    check_idle("t2.after2");

    // 3: 0x801 with 3 cycles of backpressure
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; vec_i = 12'h801;
    step();
    in_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_beat($sformatf("t3.hold%0d", i), 0, 12'h001, 0, 1'b0, 1'b0);
      step();
    end
    out_ready_i = 1'b1;
    check_beat("t3.b0", 0, 12'h001, 0, 1'b0, 1'b0);
    step();
    check_beat("t3.b1", 11, 12'h800, 1, 1'b1, 1'b1);
    step();
    check_idle("t3.done");

    // 4: A=0x003 then B=0x010 accepted on A's last handshake
    in_valid_i = 1'b1; vec_i = 12'h003;
    step();
    vec_i = 12'h010;
    check_beat("t4.a0", 0, 12'h001, 0, 1'b0, 1'b0);
    step();
    check_beat("t4.a1", 1, 12'h002, 1, 1'b1, 1'b1);
    step();
    in_valid_i = 1'b0;
    check_beat("t4.b0", 4, 12'h010, 0, 1'b1, 1'b1);
    step();
    check_idle("t4.done");

    // 5: all ones -> 12 beats
    in_valid_i = 1'b1; vec_i = 12'hFFF;
    step();
    in_valid_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check_beat($sformatf("t5.b%0d", i), i, 1 << i, i, (i == 11), (i == 11));
      step();
    end
    check_idle("t5.done");

    // 6: reset after the first beat of 0x0F0
    in_valid_i = 1'b1; vec_i = 12'h0F0;
    step();
    in_valid_i = 1'b0;
    check_beat("t6.b0", 4, 12'h010, 0, 1'b0, 1'b0);
    resetn = 1'b0;
    step();
    check_idle("t6.reset");
    resetn = 1'b1;
    step();
    check_idle("t6.after1");
    step();
    check_idle("t6.after2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
